// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, default widths and issue-stage state encoding.
// ALU_ISSUE_BYPASS_EN (optional) enables write-back forwarding in alu_issue_stage.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned RIDX_DEFAULT = 5;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } issue_state_e;

endpackage

// File: rtl/alu_fwd_mux.sv
// Single-operand write-back forwarding select: replaces the operand with the retiring
// result when indices match. Register index 0 is never forwarded.
module alu_fwd_mux
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned RIDX = RIDX_DEFAULT
) (
    input  logic [RIDX-1:0] idx_i,
    input  logic [XLEN-1:0] data_i,
    input  logic            wb_valid_i,
    input  logic [RIDX-1:0] wb_idx_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] data_o
);

    logic hit;

    always_comb begin
        hit    = wb_valid_i && (wb_idx_i == idx_i) && (wb_idx_i != '0);
        data_o = hit ? wb_data_i : data_i;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: 2-entry skid buffer (main drives outputs, skid holds overflow).
// Define ALU_ISSUE_BYPASS_EN to forward write-back results into captured and held operands.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned RIDX = RIDX_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [RIDX-1:0] in_rs1_idx,
    input  logic [RIDX-1:0] in_rs2_idx,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [RIDX-1:0] in_rd_idx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_op,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [RIDX-1:0] out_rd_idx,
    input  logic            wb_valid,
    input  logic [RIDX-1:0] wb_idx,
    input  logic [XLEN-1:0] wb_data
);

    issue_state_e    state_q;
    logic            in_ready_q;

    logic [3:0]      main_op_q, skid_op_q;
    logic [XLEN-1:0] main_rs1_q, main_rs2_q, skid_rs1_q, skid_rs2_q;
    logic [RIDX-1:0] main_rd_q, skid_rd_q;

    // Operand values after any forwarding has been applied this cycle.
    logic [XLEN-1:0] cap_rs1, cap_rs2;
    logic [XLEN-1:0] main_rs1_cur, main_rs2_cur, skid_rs1_cur, skid_rs2_cur;

    logic in_fire, out_fire;
    logic load_main_in, load_main_skid, load_skid_in;

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != StEmpty);
    assign out_op     = main_op_q;
    assign out_rs1    = main_rs1_q;
    assign out_rs2    = main_rs2_q;
    assign out_rd_idx = main_rd_q;

    always_comb begin
        in_fire        = in_valid && in_ready_q;
        out_fire       = out_valid && out_ready;
        load_main_in   = in_fire && ((state_q == StEmpty) || ((state_q == StOne) && out_fire));
        load_skid_in   = in_fire && (state_q == StOne) && !out_fire;
        load_main_skid = (state_q == StFull) && out_fire;
    end

`ifdef ALU_ISSUE_BYPASS_EN
    logic [RIDX-1:0] main_rs1_idx_q, main_rs2_idx_q, skid_rs1_idx_q, skid_rs2_idx_q;

    alu_fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_cap_rs1 (
        .idx_i      (in_rs1_idx),
        .data_i     (in_rs1),
        .wb_valid_i (wb_valid),
        .wb_idx_i   (wb_idx),
        .wb_data_i  (wb_data),
        .data_o     (cap_rs1)
    );

    alu_fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_cap_rs2 (
        .idx_i      (in_rs2_idx),
        .data_i     (in_rs2),
        .wb_valid_i (wb_valid),
        .wb_idx_i   (wb_idx),
        .wb_data_i  (wb_data),
        .data_o     (cap_rs2)
    );

    alu_fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_main_rs1 (
        .idx_i      (main_rs1_idx_q),
        .data_i     (main_rs1_q),
        .wb_valid_i (wb_valid),
        .wb_idx_i   (wb_idx),
        .wb_data_i  (wb_data),
        .data_o     (main_rs1_cur)
    );

    alu_fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_main_rs2 (
        .idx_i      (main_rs2_idx_q),
        .data_i     (main_rs2_q),
        .wb_valid_i (wb_valid),
        .wb_idx_i   (wb_idx),
        .wb_data_i  (wb_data),
        .data_o     (main_rs2_cur)
    );

    alu_fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_skid_rs1 (
        .idx_i      (skid_rs1_idx_q),
        .data_i     (skid_rs1_q),
        .wb_valid_i (wb_valid),
        .wb_idx_i   (wb_idx),
        .wb_data_i  (wb_data),
        .data_o     (skid_rs1_cur)
    );

    alu_fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_skid_rs2 (
        .idx_i      (skid_rs2_idx_q),
        .data_i     (skid_rs2_q),
        .wb_valid_i (wb_valid),
        .wb_idx_i   (wb_idx),
        .wb_data_i  (wb_data),
        .data_o     (skid_rs2_cur)
    );

    // Source indices travel with each entry so held operands can keep refreshing.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_rs1_idx_q <= '0;
            main_rs2_idx_q <= '0;
            skid_rs1_idx_q <= '0;
            skid_rs2_idx_q <= '0;
        end else begin
            if (load_main_in) begin
                main_rs1_idx_q <= in_rs1_idx;
                main_rs2_idx_q <= in_rs2_idx;
            end else if (load_main_skid) begin
                main_rs1_idx_q <= skid_rs1_idx_q;
                main_rs2_idx_q <= skid_rs2_idx_q;
            end
            if (load_skid_in) begin
                skid_rs1_idx_q <= in_rs1_idx;
                skid_rs2_idx_q <= in_rs2_idx;
            end
        end
    end
`else
    assign cap_rs1      = in_rs1;
    assign cap_rs2      = in_rs2;
    assign main_rs1_cur = main_rs1_q;
    assign main_rs2_cur = main_rs2_q;
    assign skid_rs1_cur = skid_rs1_q;
    assign skid_rs2_cur = skid_rs2_q;

    logic unused_fwd;
    assign unused_fwd = ^{wb_valid, wb_idx, wb_data, in_rs1_idx, in_rs2_idx};
`endif

    // Occupancy FSM; in_ready is registered from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (in_fire && !out_fire) begin
                        state_q    <= StFull;
                        in_ready_q <= 1'b0;
                    end else if (!in_fire && out_fire) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        state_q    <= StOne;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= StEmpty;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_op_q  <= '0;
            main_rs1_q <= '0;
            main_rs2_q <= '0;
            main_rd_q  <= '0;
            skid_op_q  <= '0;
            skid_rs1_q <= '0;
            skid_rs2_q <= '0;
            skid_rd_q  <= '0;
        end else begin
            if (load_main_in) begin
                main_op_q  <= in_op;
                main_rs1_q <= cap_rs1;
                main_rs2_q <= cap_rs2;
                main_rd_q  <= in_rd_idx;
            end else if (load_main_skid) begin
                main_op_q  <= skid_op_q;
                main_rs1_q <= skid_rs1_cur;
                main_rs2_q <= skid_rs2_cur;
                main_rd_q  <= skid_rd_q;
            end else begin
                main_rs1_q <= main_rs1_cur;
                main_rs2_q <= main_rs2_cur;
            end
            if (load_skid_in) begin
                skid_op_q  <= in_op;
                skid_rs1_q <= cap_rs1;
                skid_rs2_q <= cap_rs2;
                skid_rd_q  <= in_rd_idx;
            end else begin
                skid_rs1_q <= skid_rs1_cur;
                skid_rs2_q <= skid_rs2_cur;
            end
        end
    end

endmodule
